serial_subtractor: RTL

- Bit-serial word subtractor; the sequential counterpart of the team's combinational half-adder work, built around the half/full subtractor (difference plus borrow) in place of the sum/carry cell.
- Loads two WIDTH-bit operands and produces A - B LSB-first, one bit per clock, with a single borrow flip-flop.
- Presents the assembled word, final borrow and a done pulse.
- Sits between a parallel operand source and a serial consumer, or is used standalone as an area-minimal subtractor.

---
 rtl/serial_subtractor_if.sv | 47 ++++
 rtl/serial_subtractor.sv | 128 ++++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor; mode_in exists only when
// SERIAL_SUBTRACTOR_ADD_MODE_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
) ();
  // start_in is a request sampled only while the block is idle: there is no
  // ready signal, the source watches busy_out (low = a start will be taken on
  // this edge) and done_out marks the single cycle in which diff_out/borrow_out
  // first carry the new result.
  logic             start_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  logic             mode_in;
`endif
  logic             busy_out;
  logic             diff_bit_out;
  logic             diff_bit_valid_out;
  logic [WIDTH-1:0] diff_out;
  logic             borrow_out;
  logic             done_out;
  logic [1:0]       state_dbg_out;

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  modport master (
    output start_in, a_in, b_in, mode_in,
    input  busy_out, diff_bit_out, diff_bit_valid_out, diff_out, borrow_out,
    input  done_out, state_dbg_out
  );
  modport slave (
    input  start_in, a_in, b_in, mode_in,
    output busy_out, diff_bit_out, diff_bit_valid_out, diff_out, borrow_out,
    output done_out, state_dbg_out
  );
`else
  modport master (
    output start_in, a_in, b_in,
    input  busy_out, diff_bit_out, diff_bit_valid_out, diff_out, borrow_out,
    input  done_out, state_dbg_out
  );
  modport slave (
    input  start_in, a_in, b_in,
    output busy_out, diff_bit_out, diff_bit_valid_out, diff_out, borrow_out,
    output done_out, state_dbg_out
  );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, with a single borrow flip-flop.
// Defining SERIAL_SUBTRACTOR_ADD_MODE_EN adds mode_in (1 = full-adder cell).
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic                clk_in,
  input logic                rst_in,
  serial_subtractor_if.slave bus_if
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bit_a, bit_b, cell_sum, cell_br;

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  logic mode_q, mode_d;

  always_comb begin
    mode_d = mode_q;
    if (state_q == IDLE && bus_if.start_in) mode_d = bus_if.mode_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) mode_q <= 1'b0;
    else        mode_q <= mode_d;
  end
`endif

  // Half/full subtractor cell; the add cell reuses the same sum term.
  always_comb begin
    bit_a    = a_sr_q[0];
    bit_b    = b_sr_q[0];
    cell_sum = bit_a ^ bit_b ^ br_q;
    cell_br  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    if (mode_q) cell_br = (bit_a & bit_b) | (br_q & (bit_a ^ bit_b));
`endif
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus_if.start_in) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at bit 0.
  always_comb begin
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_d    = res_q;
    diff_d   = diff_q;
    br_d     = br_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus_if.start_in) begin
          a_sr_d = bus_if.a_in;
          b_sr_d = bus_if.b_in;
          br_d   = 1'b0;
          cnt_d  = '0;
        end
      end
      SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        res_d  = {cell_sum, res_q[WIDTH-1:1]};
        br_d   = cell_br;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          diff_d   = {cell_sum, res_q[WIDTH-1:1]};
          borrow_d = cell_br;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus_if.busy_out           = (state_q != IDLE);
    bus_if.diff_bit_valid_out = (state_q == SHIFT);
    bus_if.diff_bit_out       = (state_q == SHIFT) ? cell_sum : 1'b0;
    bus_if.diff_out           = diff_q;
    bus_if.borrow_out         = borrow_q;
    bus_if.done_out           = (state_q == DONE);
    bus_if.state_dbg_out      = state_q;
  end
endmodule
